ir_rx_letter_queue: RTL and testbench

Receive-side letter queue between the IR decoder and the Enigma decoder instance. Captures each 5-bit letter code reported by the IR decoder and stores it in a circular buffer. Replays the stored letters one at a time into the Enigma decoder under that module's ready handshake. It mirrors the transmit-side BRAM buffer that feeds the IR transmitter and absorbs IR bursts arriving while the Enigma decoder is busy.

---
 rtl/ir_letter_pkg.sv | 15 +
 rtl/letter_ring_ram.sv | 39 +++
 rtl/ir_rx_letter_queue.sv | 150 +++++++++++++++
 tb/tb_ir_rx_letter_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_letter_pkg.sv
// Shared definitions for the IR receive letter path.
// Holds the letter code width, the alphabet size and the read-FSM state type.
package ir_letter_pkg;

  localparam int unsigned LETTER_WIDTH = 5;
  localparam int unsigned NUM_LETTERS  = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/letter_ring_ram.sv
// Simple dual-port letter storage, DEPTH x LETTER_WIDTH.
// One write port and one registered read port (one-cycle read latency).
// Contents are not reset, so the array maps onto block RAM.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - letter to store
//   raddr  - read address
//   rdata  - letter at raddr, registered on the next edge
module letter_ring_ram
  import ir_letter_pkg::*;
#(
  parameter int unsigned DEPTH = 1000,
  parameter int unsigned AW    = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [LETTER_WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [LETTER_WIDTH-1:0] rdata
);

  logic [LETTER_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ir_rx_letter_queue.sv
// Receive-side letter queue between the IR decoder and the Enigma decoder.
// Buffers 5-bit letter codes in a circular buffer and replays them one at a
// time whenever the Enigma decoder reports ready.
// Optional feature: define LETTER_RANGE_CHECK_EN to discard codes >= 26.
// Ports:
//   clk_in         - system clock
//   rst_in         - synchronous active-low reset
//   code_in        - letter code from the IR decoder
//   new_code_in    - strobe, code_in valid
//   ready_in       - Enigma decoder ready (sampled only in IDLE)
//   data_valid_out - strobe, data_out holds a letter
//   data_out       - letter for the Enigma decoder
//   count_out      - letters currently stored
//   overflow_out   - sticky, a letter was dropped on a full buffer
//   dropped_out    - saturating count of dropped letters
module ir_rx_letter_queue
  import ir_letter_pkg::*;
#(
  parameter int unsigned DEPTH       = 1000,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [LETTER_WIDTH-1:0]    code_in,
  input  logic                       new_code_in,
  input  logic                       ready_in,
  output logic                       data_valid_out,
  output logic [LETTER_WIDTH-1:0]    data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out,
  output logic [7:0]                 dropped_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  rd_state_t               state;
  rd_state_t               state_nxt;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [HW-1:0]           hold_cnt;
  logic [LETTER_WIDTH-1:0] ram_rdata;
  logic                    full_c;
  logic                    in_range_c;
  logic                    wr_en_c;
  logic                    rd_en_c;
  logic                    drop_c;
  logic                    hold_done_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef LETTER_RANGE_CHECK_EN
  assign in_range_c = (code_in < LETTER_WIDTH'(NUM_LETTERS));
`else
  assign in_range_c = 1'b1;
`endif

  // Fullness uses the registered count, so a write on an ISSUE cycle into a
  // full buffer is still dropped.
  assign full_c      = (count_out == CW'(DEPTH));
  assign wr_en_c     = new_code_in & in_range_c & ~full_c;
  assign drop_c      = new_code_in & ~wr_en_c;
  assign rd_en_c     = (state == ST_ISSUE);
  assign hold_done_c = ((32'(hold_cnt) + 32'd1) >= HOLD_CYCLES);

  letter_ring_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk_in),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (code_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Read FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if ((count_out != '0) && ready_in) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD: begin
        if (hold_done_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pointers, occupancy, output registers and drop bookkeeping.
  // rd_ptr is presented to the RAM continuously, so the letter is already in
  // ram_rdata during FETCH and is registered onto data_out for the ISSUE cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_out      <= '0;
      hold_cnt       <= '0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
      overflow_out   <= 1'b0;
      dropped_out    <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_en_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_en_c, rd_en_c})
        2'b10:   count_out <= count_out + CW'(1);
        2'b01:   count_out <= count_out - CW'(1);
        default: count_out <= count_out;
      endcase
      hold_cnt       <= (state == ST_HOLD) ? hold_cnt + HW'(1) : '0;
      data_valid_out <= (state == ST_FETCH);
      if (state == ST_FETCH) begin
        data_out <= ram_rdata;
      end
      // Out-of-range codes count as drops but are not overflow events
      if (new_code_in && in_range_c && full_c) begin
        overflow_out <= 1'b1;
      end
      if (drop_c && (dropped_out != 8'hFF)) begin
        dropped_out <= dropped_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_rx_letter_queue.sv
`timescale 1ns/1ps
module tb_ir_rx_letter_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef LETTER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [4:0]    code_in;
  logic          new_code_in;
  logic          ready_in;
  logic          data_valid_out;
  logic [4:0]    data_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  logic [7:0]    dropped_out;

  ir_rx_letter_queue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .code_in        (code_in),
    .new_code_in    (new_code_in),
    .ready_in       (ready_in),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .count_out      (count_out),
    .overflow_out   (overflow_out),
    .dropped_out    (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and output monitor
  logic [4:0] exp_q[$];
  int         vcyc[$];
  int         vcount  = 0;
  int         coinc   = 0;
  int         max_cnt = 0;

  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) begin
      vcyc.push_back(cyc);
      vcount++;
      if (new_code_in) coinc++;
      if (exp_q.size() == 0) check_eq("unexpected_valid", 32'(data_valid_out), 32'd0);
      else check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
    if (32'(count_out) > max_cnt) max_cnt = 32'(count_out);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic write_code(input logic [4:0] c, input bit accept);
    code_in     = c;
    new_code_in = 1'b1;
    if (accept) exp_q.push_back(c);
    tick(1);
    new_code_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || count_out != '0) && n < 300) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    tick(HOLD + 4);
  endtask

  task automatic do_reset();
    rst_in      = 1'b0;
    new_code_in = 1'b0;
    exp_q.delete();
    tick(2);
    rst_in = 1'b1;
  endtask

  int t0;
  int v0;

  initial begin
    ready_in    = 1'b0;
    code_in     = '0;
    new_code_in = 1'b0;
    rst_in      = 1'b0;
    tick(3);

    // Reset state
    check_eq("rst_valid",    32'(data_valid_out), 32'd0);
    check_eq("rst_data",     32'(data_out),       32'd0);
    check_eq("rst_count",    32'(count_out),      32'd0);
    check_eq("rst_overflow", 32'(overflow_out),   32'd0);
    check_eq("rst_dropped",  32'(dropped_out),    32'd0);
    rst_in = 1'b1;
    tick(2);

    // Single letter: write at t0, valid at t0+3, count back to 0 at t0+4
    ready_in = 1'b1;
    tick(2);
    vcyc.delete();
    t0 = cyc;
    write_code(5'd7, 1'b1);
    check_eq("single_count_t1", 32'(count_out), 32'd1);
    tick(3);
    check_eq("single_count_t4", 32'(count_out), 32'd0);
    check_eq("single_nvalid", 32'(vcyc.size()), 32'd1);
    if (vcyc.size() >= 1) check_eq("single_latency", 32'(vcyc[0] - t0), 32'd3);
    wait_drain("single_drain");

    // Backpressure: letters accumulate, then drain in order at 3+HOLD spacing
    ready_in = 1'b0;
    vcyc.delete();
    write_code(5'd1, 1'b1);
    write_code(5'd2, 1'b1);
    write_code(5'd3, 1'b1);
    tick(4);
    check_eq("bp_count", 32'(count_out), 32'd3);
    check_eq("bp_no_output", 32'(vcyc.size()), 32'd0);
    ready_in = 1'b1;
    wait_drain("bp_drain");
    check_eq("bp_nvalid", 32'(vcyc.size()), 32'd3);
    if (vcyc.size() >= 3) begin
      check_eq("bp_space01", 32'(vcyc[1] - vcyc[0]), 32'(3 + HOLD));
      check_eq("bp_space12", 32'(vcyc[2] - vcyc[1]), 32'(3 + HOLD));
    end

    // Full / overflow
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) write_code(5'(10 + i), (i < 4));
    tick(2);
    check_eq("full_count",    32'(count_out),    32'(DEPTH));
    check_eq("full_overflow", 32'(overflow_out), 32'd1);
    check_eq("full_dropped",  32'(dropped_out),  32'd2);
    ready_in = 1'b1;
    wait_drain("full_drain");
    check_eq("full_overflow_sticky", 32'(overflow_out), 32'd1);
    check_eq("full_dropped_hold",    32'(dropped_out),  32'd2);
    do_reset();
    tick(1);
    check_eq("clr_overflow", 32'(overflow_out), 32'd0);
    check_eq("clr_dropped",  32'(dropped_out),  32'd0);
    tick(2);

    // Wrap with writes landing on ISSUE cycles
    max_cnt = 0;
    coinc   = 0;
    v0      = vcount;
    t0      = cyc;
    write_code(5'd3, 1'b1);
    write_code(5'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      while (cyc < t0 + 3 + 5 * k) tick(1);
      write_code(5'(5 + k), 1'b1);
    end
    wait_drain("wrap_drain");
    check_eq("wrap_nvalid",  32'(vcount - v0), 32'd10);
    check_eq("wrap_max_cnt", 32'(max_cnt),     32'd2);
    check_eq("wrap_coinc",   32'(coinc),       32'd8);
    check_eq("wrap_dropped", 32'(dropped_out), 32'd0);

    // Range check
    v0 = vcount;
    write_code(5'd25, 1'b1);
    write_code(5'd26, !RC);
    write_code(5'd31, !RC);
    wait_drain("range_drain");
    check_eq("range_nvalid",   32'(vcount - v0),   RC ? 32'd1 : 32'd3);
    check_eq("range_dropped",  32'(dropped_out),   RC ? 32'd2 : 32'd0);
    check_eq("range_overflow", 32'(overflow_out),  32'd0);

    // Reset during FETCH aborts delivery
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) write_code(5'(1 + i), (i < 4));
    tick(1);
    check_eq("mid_pre_overflow", 32'(overflow_out), 32'd1);
    v0       = vcount;
    ready_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    exp_q.delete();
    tick(1);
    check_eq("mid_valid",    32'(data_valid_out), 32'd0);
    check_eq("mid_count",    32'(count_out),      32'd0);
    check_eq("mid_overflow", 32'(overflow_out),   32'd0);
    check_eq("mid_dropped",  32'(dropped_out),    32'd0);
    rst_in = 1'b1;
    tick(8);
    check_eq("mid_no_delivery", 32'(vcount - v0), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
